// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit
// Brief    : Pipelined control unit for the 5-stage LEGv8 CPU. Decodes the
//            ID instruction into a 16-bit control word and carries it, with
//            destination register and valid bit, through ID/EX, EX/MEM and
//            MEM/WB. Detects load-use and flag hazards, inserts bubbles and
//            applies branch flushes and global holds.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit #(
   parameter int REGW     = 5,
   parameter int LINK_REG = 30,
   parameter int ZERO_REG = 31,
   parameter int FLAG_FWD = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     instr_id,
   input  logic            id_valid,
   input  logic            flush,
   input  logic            hold,
   output logic [15:0]     ex_ctrl,
   output logic [15:0]     mem_ctrl,
   output logic [15:0]     wb_ctrl,
   output logic [REGW-1:0] ex_rd,
   output logic [REGW-1:0] mem_rd,
   output logic [REGW-1:0] wb_rd,
   output logic            ex_valid,
   output logic            mem_valid,
   output logic            wb_valid,
   output logic            stall_if,
   output logic            illegal
);

   // Control word bit fields
   localparam logic [15:0] c_UNCOND  = 16'h0001;
   localparam logic [15:0] c_BRTAKEN = 16'h0002;
   localparam logic [15:0] c_REG2LOC = 16'h0004;
   localparam logic [15:0] c_ALUSRC  = 16'h0008;
   localparam logic [15:0] c_REGWR   = 16'h0010;
   localparam logic [15:0] c_MEM2REG = 16'h0020;
   localparam logic [15:0] c_MEMWR   = 16'h0040;
   localparam logic [15:0] c_IMM     = 16'h0080;
   localparam logic [15:0] c_BRREG   = 16'h0100;
   localparam logic [15:0] c_BRLINK  = 16'h0200;
   localparam logic [15:0] c_CMPZERO = 16'h0400;
   localparam logic [15:0] c_ALUON   = 16'h0800;
   localparam logic [15:0] c_SETFLAG = 16'h1000;
   localparam logic [15:0] c_OP_ADD  = 16'h4000;
   localparam logic [15:0] c_OP_SUB  = 16'h6000;

   localparam logic [REGW-1:0] c_LINK = REGW'(LINK_REG);
   localparam logic [REGW-1:0] c_ZERO = REGW'(ZERO_REG);

   localparam int c_B_MEM2REG = 5;
   localparam int c_B_SETFLAG = 12;

   logic [10:0]     w_op;
   logic [15:0]     w_ctrl;
   logic            w_legal;
   logic            w_use_rn;
   logic            w_use_s2;
   logic            w_bcond;
   logic            w_is_bl;
   logic [REGW-1:0] w_rd;
   logic [REGW-1:0] w_rn;
   logic [REGW-1:0] w_s2;
   logic            w_load_use;
   logic            w_flag_haz;
   logic            w_hazard;
   logic            w_unused;

   logic [15:0]     r_ex_ctrl;
   logic [15:0]     r_mem_ctrl;
   logic [15:0]     r_wb_ctrl;
   logic [REGW-1:0] r_ex_rd;
   logic [REGW-1:0] r_mem_rd;
   logic [REGW-1:0] r_wb_rd;
   logic            r_ex_valid;
   logic            r_mem_valid;
   logic            r_wb_valid;
   logic            r_illegal;

   assign w_op     = instr_id[31:21];
   assign w_unused = ^instr_id[15:10];

   // Decode the ID opcode into a control word and its register-use profile
   always_comb begin
      w_ctrl   = 16'h0000;
      w_legal  = 1'b1;
      w_use_rn = 1'b0;
      w_use_s2 = 1'b0;
      w_bcond  = 1'b0;
      w_is_bl  = 1'b0;
      if (w_op[10:5] == 6'b000101) begin
         w_ctrl = c_UNCOND | c_BRTAKEN;
      end else if (w_op[10:3] == 8'b01010100) begin
         w_ctrl  = c_BRTAKEN;
         w_bcond = 1'b1;
      end else if (w_op[10:5] == 6'b100101) begin
         w_ctrl  = c_UNCOND | c_BRTAKEN | c_BRLINK | c_REGWR | c_ALUON;
         w_is_bl = 1'b1;
      end else if (w_op == 11'b11010110000) begin
         w_ctrl   = c_UNCOND | c_BRTAKEN | c_BRREG;
         w_use_rn = 1'b1;
      end else if (w_op[10:3] == 8'b10110100) begin
         w_ctrl   = c_BRTAKEN | c_CMPZERO | c_ALUON;
         w_use_s2 = 1'b1;
      end else if (w_op[10:1] == 10'b1001000100) begin
         w_ctrl   = c_OP_ADD | c_ALUON | c_IMM | c_REGWR | c_ALUSRC;
         w_use_rn = 1'b1;
      end else if (w_op == 11'b10101011000) begin
         w_ctrl   = c_OP_ADD | c_SETFLAG | c_ALUON | c_REGWR | c_REG2LOC;
         w_use_rn = 1'b1;
         w_use_s2 = 1'b1;
      end else if (w_op == 11'b11101011000) begin
         w_ctrl   = c_OP_SUB | c_SETFLAG | c_ALUON | c_REGWR | c_REG2LOC;
         w_use_rn = 1'b1;
         w_use_s2 = 1'b1;
      end else if (w_op == 11'b11111000010) begin
         w_ctrl   = c_OP_ADD | c_ALUON | c_MEM2REG | c_REGWR | c_ALUSRC;
         w_use_rn = 1'b1;
      end else if (w_op == 11'b11111000000) begin
         w_ctrl   = c_OP_ADD | c_ALUON | c_MEMWR | c_ALUSRC;
         w_use_rn = 1'b1;
         w_use_s2 = 1'b1;
      end else begin
         w_legal = 1'b0;
      end
   end

   assign w_rd = w_is_bl ? c_LINK : REGW'(instr_id[4:0]);
   assign w_rn = REGW'(instr_id[9:5]);
   // Second source sits in Rm for R-type, in Rt for stores and CBZ
   assign w_s2 = (w_ctrl & c_REG2LOC) != 16'h0000 ? REGW'(instr_id[20:16])
                                                   : REGW'(instr_id[4:0]);

   // A load in EX whose result ID needs cannot be forwarded in time
   assign w_load_use = r_ex_valid & r_ex_ctrl[c_B_MEM2REG] & (r_ex_rd != c_ZERO)
                     & id_valid
                     & ((w_use_rn & (r_ex_rd == w_rn)) | (w_use_s2 & (r_ex_rd == w_s2)));

   generate
      if (FLAG_FWD == 0) begin : g_flag_stall
         assign w_flag_haz = id_valid & w_bcond
                           & ((r_ex_valid & r_ex_ctrl[c_B_SETFLAG])
                            | (r_mem_valid & r_mem_ctrl[c_B_SETFLAG]));
      end else begin : g_flag_fwd
         assign w_flag_haz = 1'b0;
      end
   endgenerate

   assign w_hazard = w_load_use | w_flag_haz;

   // A flushed ID instruction is dead, so its hazard must not freeze fetch
   assign stall_if = rst & (hold | (~flush & w_hazard));

   // Advance the stage registers, inserting bubbles on flush, hazard or kill
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ex_ctrl   <= 16'h0000;
         r_mem_ctrl  <= 16'h0000;
         r_wb_ctrl   <= 16'h0000;
         r_ex_rd     <= '0;
         r_mem_rd    <= '0;
         r_wb_rd     <= '0;
         r_ex_valid  <= 1'b0;
         r_mem_valid <= 1'b0;
         r_wb_valid  <= 1'b0;
         r_illegal   <= 1'b0;
      end else if (!hold) begin
         r_wb_ctrl   <= r_mem_ctrl;
         r_wb_rd     <= r_mem_rd;
         r_wb_valid  <= r_mem_valid;
         r_mem_ctrl  <= r_ex_ctrl;
         r_mem_rd    <= r_ex_rd;
         r_mem_valid <= r_ex_valid;
         if (flush || w_hazard || !id_valid || !w_legal) begin
            r_ex_ctrl  <= 16'h0000;
            r_ex_rd    <= '0;
            r_ex_valid <= 1'b0;
         end else begin
            r_ex_ctrl  <= w_ctrl;
            r_ex_rd    <= w_rd;
            r_ex_valid <= 1'b1;
         end
         r_illegal <= id_valid & ~w_legal & ~flush;
      end
   end

   assign ex_ctrl   = r_ex_ctrl;
   assign mem_ctrl  = r_mem_ctrl;
   assign wb_ctrl   = r_wb_ctrl;
   assign ex_rd     = r_ex_rd;
   assign mem_rd    = r_mem_rd;
   assign wb_rd     = r_wb_rd;
   assign ex_valid  = r_ex_valid;
   assign mem_valid = r_mem_valid;
   assign wb_valid  = r_wb_valid;
   assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl_unit
// Brief    : Bench for pipe_ctrl_unit. Two instances (flags forwarded and
//            flag-stalling) share one directed stimulus stream and are compared
//            every cycle against an instruction-level pipeline model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipe_ctrl_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr_id;
   logic        id_valid;
   logic        flush;
   logic        hold;

   logic [15:0] d_exc [2];
   logic [15:0] d_memc[2];
   logic [15:0] d_wbc [2];
   logic [4:0]  d_exr [2];
   logic [4:0]  d_memr[2];
   logic [4:0]  d_wbr [2];
   logic        d_exv [2];
   logic        d_memv[2];
   logic        d_wbv [2];
   logic        d_stall[2];
   logic        d_ill [2];

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   pipe_ctrl_unit #(.FLAG_FWD(0)) u_dut0 (
      .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid),
      .flush(flush), .hold(hold),
      .ex_ctrl(d_exc[0]), .mem_ctrl(d_memc[0]), .wb_ctrl(d_wbc[0]),
      .ex_rd(d_exr[0]), .mem_rd(d_memr[0]), .wb_rd(d_wbr[0]),
      .ex_valid(d_exv[0]), .mem_valid(d_memv[0]), .wb_valid(d_wbv[0]),
      .stall_if(d_stall[0]), .illegal(d_ill[0]));

   pipe_ctrl_unit #(.FLAG_FWD(1)) u_dut1 (
      .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid),
      .flush(flush), .hold(hold),
      .ex_ctrl(d_exc[1]), .mem_ctrl(d_memc[1]), .wb_ctrl(d_wbc[1]),
      .ex_rd(d_exr[1]), .mem_rd(d_memr[1]), .wb_rd(d_wbr[1]),
      .ex_valid(d_exv[1]), .mem_valid(d_memv[1]), .wb_valid(d_wbv[1]),
      .stall_if(d_stall[1]), .illegal(d_ill[1]));

   // ---------------- model ----------------
   typedef struct packed {
      logic       v;
      logic [15:0] c;
      logic [4:0] rd;
   } stg_t;

   typedef struct packed {
      logic        legal;
      logic [15:0] ctrl;
      logic [4:0]  rd;
      logic [4:0]  rn;
      logic [4:0]  s2;
      logic        use_rn;
      logic        use_s2;
      logic        bcond;
   } dec_t;

   stg_t m_ex[2], m_mem[2], m_wb[2];
   logic m_ill[2];

   function automatic logic [15:0] bb(input int b);
      return 16'(1) << b;
   endfunction

   function automatic logic [15:0] alu(input int code);
      return 16'(code) << 13;
   endfunction

   function automatic dec_t mdec(input logic [31:0] ins);
      dec_t d;
      d = '0;
      d.legal = 1'b1;
      d.rn = ins[9:5];
      d.rd = ins[4:0];
      casez (ins[31:21])
         11'b000101?????: d.ctrl = bb(0) | bb(1);
         11'b01010100???: begin d.ctrl = bb(1); d.bcond = 1'b1; end
         11'b100101?????: begin
            d.ctrl = bb(0) | bb(1) | bb(9) | bb(4) | bb(11) | alu(0);
            d.rd = 5'd30;
         end
         11'b11010110000: begin d.ctrl = bb(0) | bb(1) | bb(8); d.use_rn = 1'b1; end
         11'b10110100???: begin d.ctrl = bb(1) | bb(10) | bb(11); d.use_s2 = 1'b1; end
         11'b1001000100?: begin
            d.ctrl = bb(3) | bb(7) | bb(4) | bb(11) | alu(2); d.use_rn = 1'b1;
         end
         11'b10101011000: begin
            d.ctrl = bb(2) | bb(4) | bb(11) | bb(12) | alu(2);
            d.use_rn = 1'b1; d.use_s2 = 1'b1;
         end
         11'b11101011000: begin
            d.ctrl = bb(2) | bb(4) | bb(11) | bb(12) | alu(3);
            d.use_rn = 1'b1; d.use_s2 = 1'b1;
         end
         11'b11111000010: begin
            d.ctrl = bb(3) | bb(4) | bb(5) | bb(11) | alu(2); d.use_rn = 1'b1;
         end
         11'b11111000000: begin
            d.ctrl = bb(3) | bb(6) | bb(11) | alu(2);
            d.use_rn = 1'b1; d.use_s2 = 1'b1;
         end
         default: begin d.legal = 1'b0; d.ctrl = 16'h0; end
      endcase
      d.s2 = d.ctrl[2] ? ins[20:16] : ins[4:0];
      return d;
   endfunction

   // f = 0 is the flag-stalling instance, f = 1 the forwarding one
   function automatic logic mhaz(input int f);
      dec_t d;
      logic lu, fl;
      d  = mdec(instr_id);
      lu = id_valid && m_ex[f].v && m_ex[f].c[5] && (m_ex[f].rd != 5'd31) &&
           ((d.use_rn && d.rn == m_ex[f].rd) || (d.use_s2 && d.s2 == m_ex[f].rd));
      fl = (f == 0) && id_valid && d.bcond &&
           ((m_ex[f].v && m_ex[f].c[12]) || (m_mem[f].v && m_mem[f].c[12]));
      return lu || fl;
   endfunction

   function automatic logic mstall(input int f);
      return rst && (hold || (!flush && mhaz(f)));
   endfunction

   always @(posedge clk) begin
      for (int f = 0; f < 2; f++) begin
         if (!rst) begin
            m_ex[f]  <= '0;
            m_mem[f] <= '0;
            m_wb[f]  <= '0;
            m_ill[f] <= 1'b0;
         end else if (!hold) begin
            dec_t d;
            d = mdec(instr_id);
            m_wb[f]  <= m_mem[f];
            m_mem[f] <= m_ex[f];
            if (!flush && !mhaz(f) && id_valid && d.legal)
               m_ex[f] <= '{v: 1'b1, c: d.ctrl, rd: d.rd};
            else
               m_ex[f] <= '0;
            m_ill[f] <= id_valid && !d.legal && !flush;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input int f, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d: got 0x%0h want 0x%0h at %0t", nm, f, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int f = 0; f < 2; f++) begin
            chk("ex_valid",  f, 32'(d_exv[f]),  32'(m_ex[f].v));
            chk("ex_ctrl",   f, 32'(d_exc[f]),  32'(m_ex[f].c));
            chk("ex_rd",     f, 32'(d_exr[f]),  32'(m_ex[f].rd));
            chk("mem_valid", f, 32'(d_memv[f]), 32'(m_mem[f].v));
            chk("mem_ctrl",  f, 32'(d_memc[f]), 32'(m_mem[f].c));
            chk("mem_rd",    f, 32'(d_memr[f]), 32'(m_mem[f].rd));
            chk("wb_valid",  f, 32'(d_wbv[f]),  32'(m_wb[f].v));
            chk("wb_ctrl",   f, 32'(d_wbc[f]),  32'(m_wb[f].c));
            chk("wb_rd",     f, 32'(d_wbr[f]),  32'(m_wb[f].rd));
            chk("illegal",   f, 32'(d_ill[f]),  32'(m_ill[f]));
            chk("stall_if",  f, 32'(d_stall[f]), 32'(mstall(f)));
         end
      end
   end

   // ---------------- stimulus ----------------
   localparam logic [10:0] OP_ADDS = 11'b10101011000;
   localparam logic [10:0] OP_SUBS = 11'b11101011000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;

   function automatic logic [31:0] i_addi(input int rd, input int rn, input int imm);
      return {10'b1001000100, 12'(imm), 5'(rn), 5'(rd)};
   endfunction
   function automatic logic [31:0] i_r(input logic [10:0] op, input int rm,
                                       input int rn, input int rd);
      return {op, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
   endfunction
   function automatic logic [31:0] i_d(input logic [10:0] op, input int rt, input int rn);
      return {op, 9'd0, 2'b00, 5'(rn), 5'(rt)};
   endfunction
   function automatic logic [31:0] i_bl();
      return {6'b100101, 26'd16};
   endfunction
   function automatic logic [31:0] i_bcond();
      return {8'b01010100, 19'd4, 1'b0, 4'h0};
   endfunction
   function automatic logic [31:0] i_cbz(input int rt);
      return {8'b10110100, 19'd8, 5'(rt)};
   endfunction

   task automatic drv(input logic [31:0] ins, input logic v,
                      input logic fl = 1'b0, input logic hd = 1'b0);
      instr_id = ins;
      id_valid = v;
      flush    = fl;
      hold     = hd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string nm, input int f, input logic [31:0] act,
                      input logic [31:0] exp);
      chk(nm, f, act, exp);
   endtask

   initial begin
      int sc[2];
      rst = 1'b0;
      drv(i_addi(1, 0, 5), 1'b1, 1'b1, 1'b1);
      tick();
      chk_en = 1'b1;
      for (int f = 0; f < 2; f++) begin
         lit("rst_ex_valid", f, 32'(d_exv[f]), 0);
         lit("rst_ex_ctrl",  f, 32'(d_exc[f]), 0);
         lit("rst_illegal",  f, 32'(d_ill[f]), 0);
         lit("rst_stall_if", f, 32'(d_stall[f]), 0);
      end
      tick();

      // straight-line code
      rst = 1'b1;
      drv(i_addi(1, 0, 5), 1'b1);
      tick();
      lit("addi_ex_ctrl", 1, 32'(d_exc[1]), 32'h4898);
      lit("addi_ex_rd",   1, 32'(d_exr[1]), 1);
      drv(i_r(OP_ADDS, 1, 1, 2), 1'b1);
      tick();
      lit("addi_mem_ctrl", 1, 32'(d_memc[1]), 32'h4898);
      lit("adds_ex_ctrl",  1, 32'(d_exc[1]),  32'h5814);
      drv(i_d(OP_STUR, 2, 1), 1'b1);
      tick();
      lit("addi_wb_ctrl", 1, 32'(d_wbc[1]), 32'h4898);
      lit("stur_ex_ctrl", 1, 32'(d_exc[1]), 32'h4848);
      drv(32'h0, 1'b0);
      tick();

      // load-use on rn
      drv(i_d(OP_LDUR, 3, 0), 1'b1);
      tick();
      lit("ldur_ex_ctrl", 0, 32'(d_exc[0]), 32'h4838);
      drv(i_r(OP_ADDS, 5, 3, 4), 1'b1);
      #1 lit("lu_stall", 0, 32'(d_stall[0]), 1);
      tick();
      lit("lu_bubble_valid", 0, 32'(d_exv[0]), 0);
      lit("lu_bubble_ctrl",  0, 32'(d_exc[0]), 0);
      lit("lu_stall_clear",  0, 32'(d_stall[0]), 0);
      tick();
      lit("lu_adds_ex_ctrl", 0, 32'(d_exc[0]), 32'h5814);
      lit("lu_adds_ex_rd",   0, 32'(d_exr[0]), 4);

      // load to the zero register never stalls
      drv(i_d(OP_LDUR, 31, 0), 1'b1);
      tick();
      drv(i_r(OP_ADDS, 5, 31, 4), 1'b1);
      #1 lit("xzr_no_stall", 0, 32'(d_stall[0]), 0);
      tick();

      // load-use through the second source of CBZ
      drv(i_d(OP_LDUR, 6, 0), 1'b1);
      tick();
      drv(i_cbz(6), 1'b1);
      #1 lit("cbz_stall", 1, 32'(d_stall[1]), 1);
      tick();
      tick();
      lit("cbz_ex_ctrl", 1, 32'(d_exc[1]), 32'h0C02);
      drv(32'h0, 1'b0);
      tick();

      // BL then flush killing the next ADDI
      drv(i_bl(), 1'b1);
      tick();
      lit("bl_ex_rd",   1, 32'(d_exr[1]), 30);
      lit("bl_ex_ctrl", 1, 32'(d_exc[1]), 32'h0A13);
      drv(i_addi(9, 9, 1), 1'b1, 1'b1);
      #1 lit("flush_stall", 1, 32'(d_stall[1]), 0);
      tick();
      lit("flush_ex_valid", 1, 32'(d_exv[1]), 0);
      drv(32'h0, 1'b0);
      tick();
      tick();
      lit("flush_wb_valid", 1, 32'(d_wbv[1]), 0);

      // SUBS then B.cond: flag stall count per instance
      drv(i_r(OP_SUBS, 3, 2, 1), 1'b1);
      tick();
      drv(i_bcond(), 1'b1);
      sc[0] = 0;
      sc[1] = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         for (int f = 0; f < 2; f++) if (d_stall[f] === 1'b1) sc[f]++;
         tick();
      end
      lit("flag_stall_cycles", 0, 32'(sc[0]), 2);
      lit("flag_stall_cycles", 1, 32'(sc[1]), 0);
      lit("bcond_ex_ctrl", 0, 32'(d_exc[0]), 32'h0002);
      drv(32'h0, 1'b0);
      tick();

      // flush and load-use in the same cycle
      drv(i_d(OP_LDUR, 7, 0), 1'b1);
      tick();
      drv(i_r(OP_ADDS, 7, 7, 8), 1'b1, 1'b1);
      #1 lit("flush_over_haz", 0, 32'(d_stall[0]), 0);
      tick();

      // hold for three cycles mid-stream
      drv(i_addi(1, 0, 5), 1'b1);
      tick();
      drv(i_r(OP_ADDS, 1, 1, 2), 1'b1);
      tick();
      drv(i_d(OP_STUR, 2, 1), 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         #1 lit("hold_stall", 1, 32'(d_stall[1]), 1);
         tick();
         lit("hold_ex_ctrl",  1, 32'(d_exc[1]),  32'h5814);
         lit("hold_mem_ctrl", 1, 32'(d_memc[1]), 32'h4898);
      end
      drv(i_d(OP_STUR, 2, 1), 1'b1);
      tick();
      lit("resume_wb_ctrl", 1, 32'(d_wbc[1]), 32'h4898);
      lit("resume_ex_ctrl", 1, 32'(d_exc[1]), 32'h4848);

      // illegal opcode
      drv({11'h7FF, 21'h0}, 1'b1);
      tick();
      lit("illegal_pulse", 0, 32'(d_ill[0]), 1);
      lit("illegal_ex_valid", 0, 32'(d_exv[0]), 0);
      drv(32'h0, 1'b0);
      tick();
      lit("illegal_clear", 0, 32'(d_ill[0]), 0);

      // reset while a load sits in MEM, with hold and flush raised
      drv(i_d(OP_LDUR, 3, 0), 1'b1);
      tick();
      drv(32'h0, 1'b0);
      tick();
      lit("ldur_in_mem", 1, 32'(d_memc[1]), 32'h4838);
      rst = 1'b0;
      drv(i_addi(1, 0, 5), 1'b1, 1'b1, 1'b1);
      #1 lit("rst_stall_low", 1, 32'(d_stall[1]), 0);
      tick();
      for (int f = 0; f < 2; f++) begin
         lit("rst2_mem_ctrl",  f, 32'(d_memc[f]), 0);
         lit("rst2_mem_valid", f, 32'(d_memv[f]), 0);
         lit("rst2_wb_ctrl",   f, 32'(d_wbc[f]),  0);
         lit("rst2_ex_rd",     f, 32'(d_exr[f]),  0);
      end
      rst = 1'b1;
      drv(32'h0, 1'b0);
      tick();
      tick();

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
